// File: rtl/emitator_serial_param.sv
// Parametrised serial transmitter: start bit, LATIME data bits LSB-first, optional parity, NR_STOP stop bits.
// A one-word holding register lets a second word queue behind the frame in flight so frames chain with no gap.
module emitator_serial_param #(
  parameter int LATIME  = 8,
  parameter int NR_STOP = 1,
  parameter int DIV     = 1
) (
  input  logic              Ceas,
  input  logic              Reset,
  input  logic              Start,
  input  logic [LATIME-1:0] Date,
  input  logic [1:0]        Mod_paritate,
  output logic              Date_seriale,
  output logic              Pregatit,
  output logic              Ocupat,
  output logic              Gata_operatie,
  output logic              Depasire
);

  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int CNT_W = $clog2(LATIME + 1);

  typedef enum logic [2:0] {REPAUS, START, DATE, PARITATE, STOP} state_t;

  state_t            state, state_nx;
  logic [DIV_W-1:0]  div_cnt, div_cnt_nx;
  logic [CNT_W-1:0]  bit_cnt, bit_cnt_nx;
  logic [LATIME-1:0] shreg, shreg_nx, hold_data, hold_data_nx;
  logic [1:0]        hold_mode, hold_mode_nx;
  logic              par_bit, par_bit_nx, par_en, par_en_nx;
  logic              hold_full, hold_full_nx, done, done_nx, ovr, ovr_nx;
  logic              bit_last, frame_end, accept, load_new, load_hold, store_new;

  function automatic logic parity_of(input logic [LATIME-1:0] d, input logic [1:0] m);
    case (m)
      2'b01:   return ^d;
      2'b10:   return ~^d;
      default: return 1'b1;
    endcase
  endfunction

  always_ff @(posedge Ceas or posedge Reset) begin
    if (Reset) begin
      state     <= REPAUS;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      hold_data <= '0;
      hold_mode <= '0;
      par_bit   <= 1'b0;
      par_en    <= 1'b0;
      hold_full <= 1'b0;
      done      <= 1'b0;
      ovr       <= 1'b0;
    end else begin
      state     <= state_nx;
      div_cnt   <= div_cnt_nx;
      bit_cnt   <= bit_cnt_nx;
      shreg     <= shreg_nx;
      hold_data <= hold_data_nx;
      hold_mode <= hold_mode_nx;
      par_bit   <= par_bit_nx;
      par_en    <= par_en_nx;
      hold_full <= hold_full_nx;
      done      <= done_nx;
      ovr       <= ovr_nx;
    end
  end

  // A word arriving on the completion edge is taken even with the holding register full,
  // because the held word leaves for the shifter on that same edge.
  always_comb begin
    bit_last  = (div_cnt == DIV_W'(DIV - 1));
    frame_end = (state == STOP) && bit_last && (bit_cnt == CNT_W'(NR_STOP - 1));
    accept    = Start && (!hold_full || frame_end);
    load_hold = frame_end && hold_full;
    load_new  = accept && ((state == REPAUS) || (frame_end && !hold_full));
    store_new = accept && !load_new;
  end

  always_comb begin
    state_nx     = state;
    div_cnt_nx   = bit_last ? '0 : div_cnt + DIV_W'(1);
    bit_cnt_nx   = bit_cnt;
    shreg_nx     = shreg;
    hold_data_nx = hold_data;
    hold_mode_nx = hold_mode;
    par_bit_nx   = par_bit;
    par_en_nx    = par_en;
    hold_full_nx = hold_full;
    done_nx      = 1'b0;
    ovr_nx       = Start && !accept;

    case (state)
      REPAUS: begin
        div_cnt_nx = '0;
        if (load_new) state_nx = START;
      end
      START: begin
        if (bit_last) begin
          state_nx   = DATE;
          bit_cnt_nx = '0;
        end
      end
      DATE: begin
        if (bit_last) begin
          shreg_nx = shreg >> 1;
          if (bit_cnt == CNT_W'(LATIME - 1)) begin
            bit_cnt_nx = '0;
            state_nx   = par_en ? PARITATE : STOP;
          end else begin
            bit_cnt_nx = bit_cnt + CNT_W'(1);
          end
        end
      end
      PARITATE: begin
        if (bit_last) begin
          state_nx   = STOP;
          bit_cnt_nx = '0;
        end
      end
      STOP: begin
        if (bit_last) begin
          if (frame_end) begin
            done_nx  = 1'b1;
            state_nx = (load_hold || load_new) ? START : REPAUS;
          end else begin
            bit_cnt_nx = bit_cnt + CNT_W'(1);
          end
        end
      end
      default: state_nx = REPAUS;
    endcase

    if (load_new) begin
      shreg_nx   = Date;
      par_bit_nx = parity_of(Date, Mod_paritate);
      par_en_nx  = (Mod_paritate != 2'b00);
    end
    if (load_hold) begin
      shreg_nx     = hold_data;
      par_bit_nx   = parity_of(hold_data, hold_mode);
      par_en_nx    = (hold_mode != 2'b00);
      hold_full_nx = 1'b0;
    end
    if (store_new) begin
      hold_data_nx = Date;
      hold_mode_nx = Mod_paritate;
      hold_full_nx = 1'b1;
    end
  end

  always_comb begin
    case (state)
      START:    Date_seriale = 1'b0;
      DATE:     Date_seriale = shreg[0];
      PARITATE: Date_seriale = par_bit;
      default:  Date_seriale = 1'b1;
    endcase
  end

  assign Pregatit      = !hold_full;
  assign Ocupat        = (state != REPAUS);
  assign Gata_operatie = done;
  assign Depasire      = ovr;

endmodule

// File: tb/tb_emitator_serial_param.sv
// Directed bench for emitator_serial_param: one instance at 8N1/DIV=1, a second at DIV=4 with two stop bits.
// Expected line patterns are written out by hand, in transmission order, as strings of '0'/'1'.
module tb_emitator_serial_param;

  logic       clk, rst;
  logic       start, start2;
  logic [7:0] date, date2;
  logic [1:0] mode, mode2;
  logic       dser, preg, ocup, gata, dep;
  logic       dser2, preg2, ocup2, gata2, dep2;
  int         n_cmp, n_err;

  emitator_serial_param #(.LATIME(8), .NR_STOP(1), .DIV(1)) dut (
    .Ceas(clk), .Reset(rst), .Start(start), .Date(date), .Mod_paritate(mode),
    .Date_seriale(dser), .Pregatit(preg), .Ocupat(ocup), .Gata_operatie(gata), .Depasire(dep)
  );

  emitator_serial_param #(.LATIME(8), .NR_STOP(2), .DIV(4)) dut2 (
    .Ceas(clk), .Reset(rst), .Start(start2), .Date(date2), .Mod_paritate(mode2),
    .Date_seriale(dser2), .Pregatit(preg2), .Ocupat(ocup2), .Gata_operatie(gata2), .Depasire(dep2)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    n_cmp += 5;
    if (dser !== 1'b1) begin n_err++; $display("FAIL reset_line: got %b want 1", dser); end
    if (preg !== 1'b1) begin n_err++; $display("FAIL reset_pregatit: got %b want 1", preg); end
    if (ocup !== 1'b0) begin n_err++; $display("FAIL reset_ocupat: got %b want 0", ocup); end
    if (gata !== 1'b0) begin n_err++; $display("FAIL reset_gata: got %b want 0", gata); end
    if (dep !== 1'b0)  begin n_err++; $display("FAIL reset_depasire: got %b want 0", dep); end
    n_cmp += 2;
    if (dser2 !== 1'b1) begin n_err++; $display("FAIL reset_line2: got %b want 1", dser2); end
    if (ocup2 !== 1'b0) begin n_err++; $display("FAIL reset_ocupat2: got %b want 0", ocup2); end
  endtask

  // Sends one word on the DIV=1 instance and checks every line bit, Ocupat and the completion pulse.
  task automatic check_frame(input logic [7:0] d, input logic [1:0] m, input string pat, input string name);
    logic e;
    start = 1'b1; date = d; mode = m;
    step();
    start = 1'b0; date = 8'hFF; mode = 2'b11;
    for (int i = 0; i < pat.len(); i++) begin
      e = (pat[i] == "1");
      n_cmp += 3;
      if (dser !== e)    begin n_err++; $display("FAIL %s line bit %0d: got %b want %b", name, i, dser, e); end
      if (ocup !== 1'b1) begin n_err++; $display("FAIL %s ocupat idx %0d: got %b want 1", name, i, ocup); end
      if (gata !== 1'b0) begin n_err++; $display("FAIL %s early gata idx %0d: got %b want 0", name, i, gata); end
      step();
    end
    n_cmp += 3;
    if (gata !== 1'b1) begin n_err++; $display("FAIL %s gata at F: got %b want 1", name, gata); end
    if (ocup !== 1'b0) begin n_err++; $display("FAIL %s ocupat at F: got %b want 0", name, ocup); end
    if (dser !== 1'b1) begin n_err++; $display("FAIL %s idle line: got %b want 1", name, dser); end
    step();
    n_cmp++;
    if (gata !== 1'b0) begin n_err++; $display("FAIL %s gata width: got %b want 0", name, gata); end
  endtask

  task automatic test_basic_even();
    check_frame(8'hA5, 2'b01, "01010010101", "basic_even_A5");
  endtask

  task automatic test_parity_modes();
    check_frame(8'h07, 2'b01, "01110000011", "even_07");
    check_frame(8'h07, 2'b10, "01110000001", "odd_07");
    check_frame(8'h07, 2'b11, "01110000011", "mark_07");
    check_frame(8'h07, 2'b00, "0111000001",  "none_07");
  endtask

  task automatic test_divider_stop();
    string pat;
    logic  e;
    pat = "01000000111";
    start2 = 1'b1; date2 = 8'h81; mode2 = 2'b00;
    step();
    start2 = 1'b0; date2 = 8'h00;
    for (int i = 0; i < 44; i++) begin
      e = (pat[i / 4] == "1");
      n_cmp += 2;
      if (dser2 !== e)    begin n_err++; $display("FAIL div4 line idx %0d: got %b want %b", i, dser2, e); end
      if (gata2 !== 1'b0) begin n_err++; $display("FAIL div4 early gata idx %0d: got %b want 0", i, gata2); end
      step();
    end
    n_cmp += 2;
    if (gata2 !== 1'b1) begin n_err++; $display("FAIL div4 gata at 44: got %b want 1", gata2); end
    if (ocup2 !== 1'b0) begin n_err++; $display("FAIL div4 ocupat at 44: got %b want 0", ocup2); end
    step();
  endtask

  task automatic test_back_to_back();
    string pat;
    logic  e, eg;
    pat = {"01000100001", "00100010001"};
    start = 1'b1; date = 8'h11; mode = 2'b01;
    step();
    n_cmp += 2;
    if (dser !== 1'b0) begin n_err++; $display("FAIL b2b line idx 0: got %b want 0", dser); end
    if (preg !== 1'b1) begin n_err++; $display("FAIL b2b pregatit before 2nd: got %b want 1", preg); end
    date = 8'h22;
    step();
    start = 1'b0; date = 8'hFF; mode = 2'b11;
    n_cmp++;
    if (preg !== 1'b0) begin n_err++; $display("FAIL b2b pregatit after 2nd: got %b want 0", preg); end
    for (int i = 1; i <= 22; i++) begin
      eg = (i == 11) || (i == 22);
      n_cmp++;
      if (gata !== eg) begin n_err++; $display("FAIL b2b gata idx %0d: got %b want %b", i, gata, eg); end
      if (i < 22) begin
        e = (pat[i] == "1");
        n_cmp++;
        if (dser !== e) begin n_err++; $display("FAIL b2b line idx %0d: got %b want %b", i, dser, e); end
      end
      if (i == 11) begin
        n_cmp++;
        if (preg !== 1'b1) begin n_err++; $display("FAIL b2b pregatit at 11: got %b want 1", preg); end
      end
      step();
    end
    n_cmp++;
    if (ocup !== 1'b0) begin n_err++; $display("FAIL b2b ocupat after: got %b want 0", ocup); end
  endtask

  task automatic test_overrun();
    logic eg;
    start = 1'b1; date = 8'h33; mode = 2'b00;
    step();
    date = 8'h44;
    step();
    date = 8'h55;
    step();
    start = 1'b0; date = 8'hFF;
    n_cmp++;
    if (dep !== 1'b1) begin n_err++; $display("FAIL overrun depasire: got %b want 1", dep); end
    step();
    n_cmp++;
    if (dep !== 1'b0) begin n_err++; $display("FAIL overrun depasire width: got %b want 0", dep); end
    for (int i = 3; i <= 30; i++) begin
      eg = (i == 10) || (i == 20);
      n_cmp++;
      if (gata !== eg) begin n_err++; $display("FAIL overrun gata idx %0d: got %b want %b", i, gata, eg); end
      if (i == 11) begin
        n_cmp++;
        if (dser !== 1'b0) begin n_err++; $display("FAIL overrun 2nd word D0: got %b want 0", dser); end
      end
      step();
    end
    n_cmp += 2;
    if (ocup !== 1'b0) begin n_err++; $display("FAIL overrun ocupat after: got %b want 0", ocup); end
    if (preg !== 1'b1) begin n_err++; $display("FAIL overrun pregatit after: got %b want 1", preg); end
  endtask

  task automatic test_reset_mid_frame();
    start = 1'b1; date = 8'hA5; mode = 2'b01;
    step();
    start = 1'b0;
    for (int i = 0; i < 5; i++) step();
    #1 rst = 1'b1;
    #1;
    n_cmp += 3;
    if (dser !== 1'b1) begin n_err++; $display("FAIL midreset line: got %b want 1", dser); end
    if (ocup !== 1'b0) begin n_err++; $display("FAIL midreset ocupat: got %b want 0", ocup); end
    if (preg !== 1'b1) begin n_err++; $display("FAIL midreset pregatit: got %b want 1", preg); end
    step();
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      n_cmp++;
      if (gata !== 1'b0) begin n_err++; $display("FAIL midreset stray gata idx %0d: got %b want 0", i, gata); end
      step();
    end
    check_frame(8'h07, 2'b01, "01110000011", "after_reset_07");
  endtask

  initial begin
    clk = 1'b0; rst = 1'b1;
    start = 1'b0; date = 8'h00; mode = 2'b00;
    start2 = 1'b0; date2 = 8'h00; mode2 = 2'b00;
    n_cmp = 0; n_err = 0;
    #2;
    test_reset();
    step();
    rst = 1'b0;
    step();
    test_basic_even();
    test_parity_modes();
    test_divider_stop();
    test_back_to_back();
    step();
    test_overrun();
    step();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
